// File: rtl/relin_key_addr_gen.sv
// Streams relinearization-key tile addresses (digit > comp > tile order) on valid/ready; first addr 1 cycle after start.
// Stalls hold addr/tags stable while addr_ready is low; continuous mode wraps to base with no bubble.
module relin_key_addr_gen #(
    parameter int TILE_WIDTH     = 8,
    parameter int KEY_LENGTH     = 64,
    parameter int NUM_DIGITS     = 4,
    parameter int NUM_COMPONENTS = 2,
    parameter int ADDR_WIDTH     = 16,
    localparam int TILES   = KEY_LENGTH / TILE_WIDTH,
    localparam int TILE_W  = (TILES > 1) ? $clog2(TILES) : 1,
    localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int COMP_W  = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  addr_ready,
    output logic                  addr_valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DIGIT_W-1:0]    digit_idx,
    output logic [COMP_W-1:0]     comp_idx,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam logic [TILE_W-1:0]     TILE_LAST  = TILE_W'(TILES - 1);
    localparam logic [COMP_W-1:0]     COMP_LAST  = COMP_W'(NUM_COMPONENTS - 1);
    localparam logic [DIGIT_W-1:0]    DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(TILE_WIDTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [TILE_W-1:0]     tile_q, tile_d;
    logic [COMP_W-1:0]     comp_q, comp_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic                  cont_q, cont_d;
    logic                  last_beat;

    assign last_beat = (tile_q == TILE_LAST) && (comp_q == COMP_LAST) && (digit_q == DIGIT_LAST);

    // Tiles of consecutive components/digits are contiguous, so the address is a plain running sum.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        tile_d  = tile_q;
        comp_d  = comp_q;
        digit_d = digit_q;
        cont_d  = cont_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = BURST;
                    base_d  = base_addr;
                    addr_d  = base_addr;
                    cont_d  = continuous;
                    tile_d  = '0;
                    comp_d  = '0;
                    digit_d = '0;
                end
            end
            BURST: begin
                if (abort) begin
                    state_d = IDLE;
                    addr_d  = base_q;
                    tile_d  = '0;
                    comp_d  = '0;
                    digit_d = '0;
                end else if (addr_ready) begin
                    if (last_beat) begin
                        addr_d  = base_q;
                        tile_d  = '0;
                        comp_d  = '0;
                        digit_d = '0;
                        if (!cont_q) state_d = DONE;
                    end else begin
                        addr_d = addr_q + STRIDE;
                        if (tile_q == TILE_LAST) begin
                            tile_d = '0;
                            if (comp_q == COMP_LAST) begin
                                comp_d  = '0;
                                digit_d = digit_q + DIGIT_W'(1);
                            end else begin
                                comp_d = comp_q + COMP_W'(1);
                            end
                        end else begin
                            tile_d = tile_q + TILE_W'(1);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            tile_q  <= '0;
            comp_q  <= '0;
            digit_q <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            tile_q  <= tile_d;
            comp_q  <= comp_d;
            digit_q <= digit_d;
            cont_q  <= cont_d;
        end
    end

    assign addr_valid = (state_q == BURST);
    assign addr       = addr_q;
    assign digit_idx  = digit_q;
    assign comp_idx   = comp_q;
    assign last       = addr_valid && last_beat;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_relin_key_addr_gen.sv
// Bench for relin_key_addr_gen with NUM_DIGITS=2: vector table, randomized backpressure against a
// loop-index reference model, continuous wrap, abort, address overflow and async reset.
module tb_relin_key_addr_gen;

    localparam int TW    = 8;
    localparam int KL    = 64;
    localparam int ND    = 2;
    localparam int NC    = 2;
    localparam int AW    = 16;
    localparam int TILES = KL / TW;
    localparam int BEATS = ND * NC * TILES;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, continuous, abort, addr_ready;
    logic [AW-1:0] base_addr;
    logic          addr_valid, last, busy, done;
    logic [AW-1:0] addr;
    logic [0:0]    digit_idx, comp_idx;

    int n_pass  = 0;
    int n_total = 0;

    relin_key_addr_gen #(
        .TILE_WIDTH(TW), .KEY_LENGTH(KL), .NUM_DIGITS(ND), .NUM_COMPONENTS(NC), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
        .base_addr(base_addr), .addr_ready(addr_ready), .addr_valid(addr_valid), .addr(addr),
        .digit_idx(digit_idx), .comp_idx(comp_idx), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        int          beat;
        logic [15:0] exp_addr;
        int          exp_digit;
        int          exp_comp;
        int          exp_last;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: beat k decomposes directly into (digit, comp, tile) loop indices.
    function automatic int m_tile(input int k);  return k % TILES;             endfunction
    function automatic int m_comp(input int k);  return (k / TILES) % NC;      endfunction
    function automatic int m_digit(input int k); return k / (TILES * NC);      endfunction
    function automatic logic [15:0] m_addr(input logic [15:0] b, input int k);
        int sum;
        sum = int'(b) + (m_digit(k) * NC + m_comp(k)) * KL + m_tile(k) * TW;
        return 16'(sum);
    endfunction

    task automatic check_beat(input string tag, input logic [15:0] b, input int k);
        chk({tag, "_addr"},  32'(addr),      32'(m_addr(b, k)));
        chk({tag, "_digit"}, 32'(digit_idx), 32'(m_digit(k)));
        chk({tag, "_comp"},  32'(comp_idx),  32'(m_comp(k)));
        chk({tag, "_last"},  32'(last),      32'(k == BEATS - 1));
    endtask

    // Called at a negedge while idle; returns at the negedge where the first address is shown.
    task automatic start_walk(input logic [15:0] b, input logic cont);
        start      = 1'b1;
        base_addr  = b;
        continuous = cont;
        @(negedge clk);
        start      = 1'b0;
        continuous = 1'b0;
        base_addr  = 16'h0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic run_walk(input logic [15:0] b, input bit rand_rdy, output int hs_cnt, output int cycles);
        int          k = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [15:0] pa;
        logic [2:0]  ptags;
        start_walk(b, 1'b0);
        while (k < BEATS && cyc < 400) begin
            chk("walk_valid", 32'(addr_valid), 32'd1);
            chk("walk_busy",  32'(busy),       32'd1);
            chk("walk_done",  32'(done),       32'd0);
            if (stalled) begin
                chk("stall_addr", 32'(addr), 32'(pa));
                chk("stall_tags", 32'({digit_idx, comp_idx, last}), 32'(ptags));
            end
            addr_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            // Start/base/mode noise during the walk must be ignored.
            start      = ($urandom_range(0, 3) == 0);
            base_addr  = 16'h0700;
            continuous = 1'b1;
            if (addr_valid && addr_ready) begin
                check_beat("hs", b, k);
                k++;
                stalled = 0;
            end else begin
                stalled = 1;
                pa      = addr;
                ptags   = {digit_idx, comp_idx, last};
            end
            cyc++;
            @(negedge clk);
        end
        start      = 1'b0;
        continuous = 1'b0;
        addr_ready = 1'b1;
        hs_cnt     = k;
        cycles     = cyc;
        chk("done_pulse",  32'(done),       32'd1);
        chk("done_valid",  32'(addr_valid), 32'd0);
        chk("done_busy",   32'(busy),       32'd1);
        @(negedge clk);
        chk("after_done",  32'(done),       32'd0);
        chk("after_busy",  32'(busy),       32'd0);
    endtask

    initial begin
        int hs, cyc, guard;

        vecs[0] = '{16'h0100,  0, 16'h0100, 0, 0, 0};
        vecs[1] = '{16'h0100,  7, 16'h0138, 0, 0, 0};
        vecs[2] = '{16'h0100,  8, 16'h0140, 0, 1, 0};
        vecs[3] = '{16'h0100, 15, 16'h0178, 0, 1, 0};
        vecs[4] = '{16'h0100, 16, 16'h0180, 1, 0, 0};
        vecs[5] = '{16'h0100, 31, 16'h01F8, 1, 1, 1};
        vecs[6] = '{16'hFFF0,  1, 16'hFFF8, 0, 0, 0};
        vecs[7] = '{16'hFFF0,  2, 16'h0000, 0, 0, 0};
        vecs[8] = '{16'hFFF0,  3, 16'h0008, 0, 0, 0};
        vecs[9] = '{16'h0400,  0, 16'h0400, 0, 0, 0};

        reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        addr_ready = 1'b1; base_addr = 16'h0;
        #1;
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_addr",  32'(addr),       32'd0);
        chk("rst_tags",  32'({digit_idx, comp_idx, last}), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // abort in IDLE must not disturb anything
        do_abort();
        chk("idle_abort_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            start_walk(vecs[i].base, 1'b0);
            repeat (vecs[i].beat) @(negedge clk);
            chk("vec_valid", 32'(addr_valid),  32'd1);
            chk("vec_addr",  32'(addr),        32'(vecs[i].exp_addr));
            chk("vec_digit", 32'(digit_idx),   32'(vecs[i].exp_digit));
            chk("vec_comp",  32'(comp_idx),    32'(vecs[i].exp_comp));
            chk("vec_last",  32'(last),        32'(vecs[i].exp_last));
            do_abort();
        end

        run_walk(16'h0100, 1'b0, hs, cyc);
        chk("full_rate_hs",     32'(hs),  32'(BEATS));
        chk("full_rate_cycles", 32'(cyc), 32'(BEATS));

        run_walk(16'h0100, 1'b1, hs, cyc);
        chk("bp_hs", 32'(hs), 32'(BEATS));

        run_walk(16'hFFF0, 1'b1, hs, cyc);
        chk("ovf_hs", 32'(hs), 32'(BEATS));

        // Continuous: 70 full-rate cycles wrap past the last beat without a bubble.
        start_walk(16'h0000, 1'b1);
        for (int i = 0; i < 70; i++) begin
            chk("cont_valid", 32'(addr_valid), 32'd1);
            chk("cont_done",  32'(done),       32'd0);
            check_beat("cont", 16'h0000, i % BEATS);
            @(negedge clk);
        end
        do_abort();
        chk("cont_abort_valid", 32'(addr_valid), 32'd0);
        chk("cont_abort_busy",  32'(busy),       32'd0);

        // Abort coinciding with a handshake at 0x148.
        start_walk(16'h0100, 1'b0);
        guard = 0;
        while (addr !== 16'h0148 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_0x148", 32'(addr), 32'h148);
        addr_ready = 1'b1;
        do_abort();
        chk("abort_valid", 32'(addr_valid), 32'd0);
        chk("abort_busy",  32'(busy),       32'd0);
        chk("abort_done",  32'(done),       32'd0);
        @(negedge clk);
        chk("abort_done2", 32'(done),       32'd0);
        start_walk(16'h0400, 1'b0);
        chk("restart_addr",  32'(addr),      32'h400);
        chk("restart_digit", 32'(digit_idx), 32'd0);
        chk("restart_comp",  32'(comp_idx),  32'd0);
        do_abort();

        // Asynchronous reset mid-walk clears outputs before the next edge.
        start_walk(16'h0100, 1'b0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_valid", 32'(addr_valid), 32'd0);
        chk("areset_addr",  32'(addr),       32'd0);
        chk("areset_tags",  32'({digit_idx, comp_idx, last}), 32'd0);
        chk("areset_busy",  32'(busy),       32'd0);
        chk("areset_done",  32'(done),       32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume_valid", 32'(addr_valid), 32'd0);
        chk("no_resume_busy",  32'(busy),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/relin_key_addr_gen.md
# relin_key_addr_gen

Parametrised address generator for streaming relinearization keys out of key memory into the polynomial multiplier. It walks every decomposition digit and key component (a/b parts) of a relinearization key in tile-sized steps from a programmable base address, and presents each address on a valid/ready handshake so the memory and multiplier can stall it. It supports one-shot and continuous (wrapping) modes, abort, and per-beat tags (digit, component, last). It replaces the single-channel fixed-stride generator in the polynomial multiplier's relinearization path.

## Interface
- TILE_WIDTH, 8, coefficients per tile (address stride)
- KEY_LENGTH, 64, coefficients per key component; must be a multiple of TILE_WIDTH
- NUM_DIGITS, 4, decomposition digits per key
- NUM_COMPONENTS, 2, polynomials per digit
- ADDR_WIDTH, 16, address bus width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a key walk; sampled only in IDLE
- continuous  in  1  mode, latched at start: 1 = wrap to first address after the last beat and continue
- abort  in  1  synchronous return to IDLE
- base_addr  in  ADDR_WIDTH  key base address, latched at start
- addr_ready  in  1  consumer accepts the current address
- addr_valid  out  1  addr and tags are valid
- addr  out  ADDR_WIDTH  current tile address
- digit_idx  out  max(1,$clog2(NUM_DIGITS))  digit of the current beat
- comp_idx  out  max(1,$clog2(NUM_COMPONENTS))  component of the current beat
- last  out  1  current beat is the final beat of the key
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the final handshake (one-shot mode only)

## Operation
- TILES = KEY_LENGTH/TILE_WIDTH. BEATS = NUM_DIGITS*NUM_COMPONENTS*TILES.
- addr = base + ((digit*NUM_COMPONENTS + comp)*KEY_LENGTH) + tile*TILE_WIDTH, truncated modulo 2^ADDR_WIDTH.
- Iteration order: tile innermost, then comp, then digit. Counters advance only on a handshake (addr_valid & addr_ready).
- States: IDLE, BURST, DONE.
  - IDLE: start=1 and abort=0 -> latch base_addr and continuous, clear counters, go to BURST.
  - BURST: addr_valid=1. On a handshake with last=1: if continuous, clear counters and stay in BURST; otherwise go to DONE.
  - DONE: done=1 and addr_valid=0 for exactly one cycle, then IDLE.
- last = (tile==TILES-1) & (comp==NUM_COMPONENTS-1) & (digit==NUM_DIGITS-1).
- abort=1 in BURST or DONE -> IDLE next cycle with counters cleared and no done pulse. abort has priority over a simultaneous handshake and over start. abort in IDLE has no effect.
- start outside IDLE is ignored. base_addr and continuous changes outside IDLE are ignored.
- Reset values: addr_valid=0, addr=0, digit_idx=0, comp_idx=0, last=0, busy=0, done=0, state IDLE.

## Timing
- start accepted at edge N -> addr_valid=1 with the first address at N+1. Start-to-first-address latency is 1 cycle.
- While addr_valid=1 and addr_ready=0, addr, tags and last are held stable.
- Full rate: one address per cycle while addr_ready=1. A one-shot walk takes BEATS cycles of valid, plus one DONE cycle.
- Continuous wrap is seamless: the cycle after the last handshake presents base again, with no bubble.
- busy=1 from the cycle after start through the DONE cycle inclusive.
- Reset assertion mid-walk clears all outputs immediately (asynchronously). The walk does not resume after reset.

## Test plan
- Defaults with NUM_DIGITS=2, base 0x100, addr_ready=1, one-shot:
  - Expected addresses: 0x100, 0x108 … 0x138 (digit 0, comp 0); 0x140 … 0x178 (comp 1); 0x180 … 0x1F8 (digit 1).
  - 32 beats total; last=1 only on 0x1F8.
  - done pulses at beat 33; busy drops the cycle after.
- Backpressure: toggle addr_ready pseudo-randomly.
  - Address sequence is identical to the previous test.
  - addr and tags are stable across every stalled cycle.
  - Exactly 32 handshakes occur.
- Continuous mode, base 0x0, 70 cycles with ready=1:
  - addr wraps 0x1F8 -> 0x000 with no gap.
  - done is never asserted.
  - abort at cycle 70 gives addr_valid=0 and busy=0 the next cycle.
- Abort with a simultaneous handshake mid-walk (at 0x148):
  - Next cycle is IDLE with no done pulse.
  - A new start with base 0x400 gives first addr 0x400, digit_idx=0, comp_idx=0.
- Address overflow: ADDR_WIDTH=8, base 0xF0 -> addresses 0xF0, 0xF8, 0x00, 0x08 …
- Asynchronous reset low mid-BURST: all outputs go to 0 before the next clk edge. start in BURST has no effect (sequence is unchanged).
